// File: rtl/cpu_ram_responder_if.sv
// CPU memory bus between the CPU (master) and a RAM responder (slave).
// Signal names are seen from the responder's side.
`timescale 1ns / 1ps

interface cpu_ram_responder_if;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        write_i;
  logic        request_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        data_valid_o;

  modport master (
    output address_i, data_i, write_i, request_i,
    input  ready_o, data_o, data_valid_o
  );

  modport slave (
    input  address_i, data_i, write_i, request_i,
    output ready_o, data_o, data_valid_o
  );
endinterface

// File: rtl/cpu_ram_responder.sv
// Fixed-latency 2 KiB work RAM responder mirrored over an 8 KiB window.
// Define CPU_RAM_OPEN_BUS_EN to have misses answered from an open-bus latch.
`timescale 1ns / 1ps

module cpu_ram_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter logic [15:0] WINDOW_BASE = 16'h0000
) (
  input logic                  clock_i,
  input logic                  reset_ni,
  cpu_ram_responder_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  localparam logic [3:0] LoadCount = 4'(LATENCY - 1);

  state_e      state_q;
  logic [3:0]  count_q;
  logic [10:0] index_q;
  logic        write_q;
  logic        hit_q;
  logic [7:0]  wdata_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic [7:0]  mem [2048];

  logic        accept;
  logic        hit_in;
  logic        enter_respond;
  logic [10:0] resp_index;
  logic        resp_write;
  logic        resp_hit;
  logic [7:0]  resp_wdata;
  logic        mem_we;
  logic        unused_addr_bits;

  assign accept           = bus.request_i && (state_q == StIdle);
  assign hit_in           = (bus.address_i[15:13] == WINDOW_BASE[15:13]);
  assign unused_addr_bits = ^bus.address_i[12:11];

  // With LATENCY == 1 the response is built straight from the bus in the accept cycle.
  always_comb begin
    enter_respond = 1'b0;
    resp_index    = index_q;
    resp_write    = write_q;
    resp_hit      = hit_q;
    resp_wdata    = wdata_q;
    if (state_q == StIdle) begin
      enter_respond = accept && (LATENCY == 1);
      resp_index    = bus.address_i[10:0];
      resp_write    = bus.write_i;
      resp_hit      = hit_in;
      resp_wdata    = bus.data_i;
    end else if (state_q == StWait) begin
      enter_respond = (count_q == 4'd1);
    end
  end

  // Gated by reset so a request seen while reset is held cannot commit.
  assign mem_we = enter_respond && resp_hit && resp_write && reset_ni;

  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      mem[resp_index] <= resp_wdata;
    end
  end

`ifdef CPU_RAM_OPEN_BUS_EN
  logic [7:0] latch_q;
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      index_q <= 11'd0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      wdata_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
`ifdef CPU_RAM_OPEN_BUS_EN
      latch_q <= 8'h00;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            index_q <= bus.address_i[10:0];
            write_q <= bus.write_i;
            hit_q   <= hit_in;
            wdata_q <= bus.data_i;
            count_q <= LoadCount;
            state_q <= (LATENCY == 1) ? StRespond : StWait;
`ifdef CPU_RAM_OPEN_BUS_EN
            if (bus.write_i) latch_q <= bus.data_i;
`endif
          end
        end
        StWait: begin
          count_q <= 4'(count_q - 4'd1);
          if (count_q == 4'd1) state_q <= StRespond;
        end
        StRespond: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase

      if (enter_respond) begin
        if (resp_hit) begin
          valid_q <= 1'b1;
          data_q  <= resp_write ? resp_wdata : mem[resp_index];
`ifdef CPU_RAM_OPEN_BUS_EN
          latch_q <= resp_write ? resp_wdata : mem[resp_index];
`endif
        end else begin
`ifdef CPU_RAM_OPEN_BUS_EN
          // A miss write already refreshed the latch at accept; reads replay it.
          valid_q <= 1'b1;
          data_q  <= resp_write ? resp_wdata : latch_q;
          latch_q <= resp_write ? resp_wdata : latch_q;
`endif
        end
      end
    end
  end

  assign bus.ready_o      = (state_q == StIdle);
  assign bus.data_o       = data_q;
  assign bus.data_valid_o = valid_q;

endmodule

// File: tb/tb_cpu_ram_responder.sv
// Directed bench for cpu_ram_responder at LATENCY 2, 1 and 15.
`timescale 1ns / 1ps

module tb_cpu_ram_responder;

`ifdef CPU_RAM_OPEN_BUS_EN
  localparam logic OpenBus = 1'b1;
`else
  localparam logic OpenBus = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        we = 1'b0;
  logic [2:0]  req = 3'b000;
  int          sel = 0;
  logic        rdy;
  logic        vld;
  logic [7:0]  dat;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cpu_ram_responder_if bus0 ();
  cpu_ram_responder_if bus1 ();
  cpu_ram_responder_if bus2 ();

  assign bus0.address_i = addr;
  assign bus0.data_i    = wdata;
  assign bus0.write_i   = we;
  assign bus0.request_i = req[0];
  assign bus1.address_i = addr;
  assign bus1.data_i    = wdata;
  assign bus1.write_i   = we;
  assign bus1.request_i = req[1];
  assign bus2.address_i = addr;
  assign bus2.data_i    = wdata;
  assign bus2.write_i   = we;
  assign bus2.request_i = req[2];

  cpu_ram_responder #(.LATENCY(2), .WINDOW_BASE(16'h0000)) dut_l2 (
    .clock_i(clk), .reset_ni(reset_n), .bus(bus0)
  );
  cpu_ram_responder #(.LATENCY(1), .WINDOW_BASE(16'h0000)) dut_l1 (
    .clock_i(clk), .reset_ni(reset_n), .bus(bus1)
  );
  cpu_ram_responder #(.LATENCY(15), .WINDOW_BASE(16'h0000)) dut_l15 (
    .clock_i(clk), .reset_ni(reset_n), .bus(bus2)
  );

  always_comb begin
    rdy = bus0.ready_o;
    vld = bus0.data_valid_o;
    dat = bus0.data_o;
    if (sel == 1) begin
      rdy = bus1.ready_o;
      vld = bus1.data_valid_o;
      dat = bus1.data_o;
    end else if (sel == 2) begin
      rdy = bus2.ready_o;
      vld = bus2.data_valid_o;
      dat = bus2.data_o;
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; cycle k after the accept cycle must show the response at k == lat.
  task automatic run_req(input int dut, input logic [15:0] a, input logic [7:0] d,
                         input logic w, input logic exp_v, input logic [7:0] exp_d,
                         input int lat, input string tag);
    @(negedge clk);
    sel = dut;
    addr = a;
    wdata = d;
    we = w;
    req[dut] = 1'b1;
    #1;
    check_eq({tag, " ready before"}, 16'(rdy), 16'd1);
    @(posedge clk);
    #1;
    req[dut] = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      check_eq($sformatf("%s valid k=%0d", tag, k), 16'(vld), 16'(exp_v && (k == lat)));
      check_eq($sformatf("%s ready k=%0d", tag, k), 16'(rdy), 16'(k == lat + 1));
      if (k == lat) check_eq({tag, " data"}, 16'(dat), 16'(exp_d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;

    // Reset held for three cycles: all responders idle with cleared outputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        sel = d;
        #1;
        check_eq($sformatf("reset ready dut%0d", d), 16'(rdy), 16'd1);
        check_eq($sformatf("reset valid dut%0d", d), 16'(vld), 16'd0);
        check_eq($sformatf("reset data dut%0d", d), 16'(dat), 16'h00);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Write then aliased read at latency 2.
    run_req(0, 16'h0005, 8'hA5, 1'b1, 1'b1, 8'hA5, 2, "wr 0005");
    run_req(0, 16'h1805, 8'h00, 1'b0, 1'b1, 8'hA5, 2, "rd 1805");

    // Reset aborts a pending write.
    run_req(0, 16'h0010, 8'h11, 1'b1, 1'b1, 8'h11, 2, "wr 0010 prior");
    @(negedge clk);
    sel = 0;
    addr = 16'h0010;
    wdata = 8'h3C;
    we = 1'b1;
    req[0] = 1'b1;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    check_eq("abort wait ready", 16'(rdy), 16'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("abort reset ready", 16'(rdy), 16'd1);
    check_eq("abort reset valid", 16'(vld), 16'd0);
    @(posedge clk);
    #1;
    check_eq("abort no ack", 16'(vld), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort after release", 16'(vld), 16'd0);
    run_req(0, 16'h0010, 8'h00, 1'b0, 1'b1, 8'h11, 2, "rd 0010 after abort");

    // Miss after a hit read of A5.
    run_req(0, 16'h0005, 8'h00, 1'b0, 1'b1, 8'hA5, 2, "rd 0005");
    run_req(0, 16'h4000, 8'h00, 1'b0, OpenBus, 8'hA5, 2, "rd 4000 miss");

    // Latency 1 with request held high: accept every other cycle.
    run_req(1, 16'h0005, 8'h77, 1'b1, 1'b1, 8'h77, 1, "l1 wr 0005");
    @(negedge clk);
    sel = 1;
    addr = 16'h0005;
    we = 1'b0;
    req[1] = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (vld) pulses++;
      check_eq($sformatf("l1 stream valid k=%0d", k), 16'(vld), 16'(k % 2));
      check_eq($sformatf("l1 stream ready k=%0d", k), 16'(rdy), 16'(1 - (k % 2)));
      if (k % 2 == 1) check_eq($sformatf("l1 stream data k=%0d", k), 16'(dat), 16'h77);
    end
    req[1] = 1'b0;
    check_eq("l1 stream pulse count", 16'(pulses), 16'd5);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_eq("l1 stream quiet", 16'(vld), 16'd0);
    end

    // Latency 15 write and aliased read.
    run_req(2, 16'h0123, 8'h5A, 1'b1, 1'b1, 8'h5A, 15, "l15 wr 0123");
    run_req(2, 16'h0923, 8'h00, 1'b0, 1'b1, 8'h5A, 15, "l15 rd 0923");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
